// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU memory subsystem.
// Slot encoding for the VRAM arbiter and the CPU write record.
package ppu_pkg;

  localparam int PPU_ADDR_W = 12;
  localparam int PPU_DATA_W = 32;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_READ,
    SLOT_WRITE
  } slot_t;

  typedef struct packed {
    logic [PPU_ADDR_W-1:0] addr;
    logic [PPU_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/ppu_wr_fifo.sv
// Synchronous FIFO for buffered CPU writes (push/pop/full/empty/head).
// Ports: clk, reset, push, pop, din in; full, empty, head out.
module ppu_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 44
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Extra MSB tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// Shares one single-port VRAM between render reads (priority) and queued
// CPU writes, with a starvation guard. Ports: cpu_* bus, ren_* render, mem_*.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int ADDR_W       = PPU_ADDR_W,
  parameter int DATA_W       = PPU_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_chipselect,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic              cpu_waitrequest,
  input  logic              ren_req,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic              ren_grant,
  output logic              ren_rvalid,
  output logic [DATA_W-1:0] ren_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT   = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [CW-1:0]            starve_cnt;
  logic                     force_cpu;
  logic                     rd_sel;
  logic                     wr_sel;
  slot_t                    slot_nxt;
  slot_t                    slot_q;

  assign push            = cpu_chipselect & cpu_write & ~full;
  assign cpu_waitrequest = cpu_chipselect & cpu_write & full;

  ppu_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({cpu_address, cpu_write_data}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign force_cpu = ~empty & (starve_cnt == LIMIT);

  // Made mutually exclusive so the decoder stays one-hot; no memory
  // traffic is issued while reset is held.
  assign rd_sel = ~reset & ren_req & ~force_cpu;
  assign wr_sel = ~reset & ~rd_sel & ~empty;

  always_comb begin
    slot_nxt  = SLOT_IDLE;
    pop       = 1'b0;
    ren_grant = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      rd_sel: begin
        slot_nxt  = SLOT_READ;
        ren_grant = 1'b1;
        mem_addr  = ren_addr;
      end
      wr_sel: begin
        slot_nxt  = SLOT_WRITE;
        pop       = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head[ADDR_W+DATA_W-1:DATA_W];
        mem_wdata = head[DATA_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= SLOT_IDLE;
    end else begin
      slot_q <= slot_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || pop || empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CNT_ONE;
    end
  end

  assign ren_rvalid = (slot_q == SLOT_READ);
  assign ren_rdata  = ren_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Self-checking bench for ppu_vram_arbiter: vector table, directed
// sequences, and a scoreboard monitor for write order and read returns.
module tb_ppu_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_chipselect = 1'b0;
  logic        cpu_write = 1'b0;
  logic [11:0] cpu_address = '0;
  logic [31:0] cpu_write_data = '0;
  logic        cpu_waitrequest;
  logic        ren_req = 1'b0;
  logic [11:0] ren_addr = '0;
  logic        ren_grant;
  logic        ren_rvalid;
  logic [31:0] ren_rdata;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wexp_t;

  wexp_t       wq[$];
  logic [31:0] rq[$];
  logic        prev_grant = 1'b0;

  typedef struct {
    logic        cs;
    logic        rr;
    logic [11:0] ra;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        e_wait;
    logic        e_grant;
    logic        e_we;
    logic [11:0] e_addr;
  } vec_t;

  ppu_vram_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_chipselect  (cpu_chipselect),
    .cpu_write       (cpu_write),
    .cpu_address     (cpu_address),
    .cpu_write_data  (cpu_write_data),
    .cpu_waitrequest (cpu_waitrequest),
    .ren_req         (ren_req),
    .ren_addr        (ren_addr),
    .ren_grant       (ren_grant),
    .ren_rvalid      (ren_rvalid),
    .ren_rdata       (ren_rdata),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data is address + 1, one cycle after the address.
  always @(posedge clk) mem_rdata <= 32'(mem_addr) + 32'd1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(logic en, logic [11:0] a, logic [31:0] d);
    cpu_chipselect = en;
    cpu_write      = en;
    cpu_address    = a;
    cpu_write_data = d;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      wq.delete();
      rq.delete();
      prev_grant = 1'b0;
    end else begin
      chk("rvalid_timing", ren_rvalid, prev_grant);
      if (ren_rvalid) begin
        chk("rd_queue_nonempty", rq.size() != 0, 1);
        if (rq.size() != 0) chk("rdata", ren_rdata, rq.pop_front());
      end else begin
        chk("rdata_zero", ren_rdata, 0);
      end
      if (mem_we) begin
        chk("wr_queue_nonempty", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          wexp_t e;
          e = wq.pop_front();
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", mem_wdata, e.d);
        end
      end
      if (ren_grant) begin
        chk("grant_addr", mem_addr, ren_addr);
        chk("grant_no_we", mem_we, 0);
      end
      prev_grant = ren_grant;
      if (ren_grant) rq.push_back(32'(ren_addr) + 32'd1);
      if (cpu_chipselect && cpu_write && !cpu_waitrequest)
        wq.push_back('{cpu_address, cpu_write_data});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[7];
    logic w4_acc;
    logic exp_force;

    tv[0] = '{1'b0, 1'b0, 12'h000, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 12'h000};
    tv[1] = '{1'b1, 1'b0, 12'h000, 12'h010, 32'hDEADBEEF,
              1'b0, 1'b0, 1'b0, 12'h000};
    tv[2] = '{1'b0, 1'b0, 12'h000, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1, 12'h010};
    tv[3] = '{1'b0, 1'b1, 12'h200, 12'h000, 32'h0, 1'b0, 1'b1, 1'b0, 12'h200};
    tv[4] = '{1'b1, 1'b1, 12'h200, 12'h020, 32'h12345678,
              1'b0, 1'b1, 1'b0, 12'h200};
    tv[5] = '{1'b0, 1'b0, 12'h000, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1, 12'h020};
    tv[6] = '{1'b0, 1'b0, 12'h000, 12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 12'h000};

    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctl", {cpu_waitrequest, ren_grant, ren_rvalid, mem_we}, 0);
      chk("idle_addr", mem_addr, 0);
      chk("idle_wdata", mem_wdata, 0);
      chk("idle_rdata", ren_rdata, 0);
      step();
    end

    // Vector table
    for (int i = 0; i < 7; i++) begin
      drive_wr(tv[i].cs, tv[i].ca, tv[i].cd);
      ren_req  = tv[i].rr;
      ren_addr = tv[i].ra;
      @(negedge clk);
      chk("vec_wait", cpu_waitrequest, tv[i].e_wait);
      chk("vec_grant", ren_grant, tv[i].e_grant);
      chk("vec_we", mem_we, tv[i].e_we);
      chk("vec_addr", mem_addr, tv[i].e_addr);
      if (i == 2) chk("vec_wdata", mem_wdata, 32'hDEADBEEF);
      step();
    end
    drive_wr(1'b0, '0, '0);
    ren_req = 1'b0;

    // Back-to-back render reads
    for (int i = 0; i < 4; i++) begin
      ren_req  = 1'b1;
      ren_addr = 12'h100 + 12'(i);
      @(negedge clk);
      chk("burst_grant", ren_grant, 1);
      if (i > 0) begin
        chk("burst_rvalid", ren_rvalid, 1);
        chk("burst_rdata", ren_rdata, 32'h100 + 32'(i));
      end
      step();
    end
    ren_req = 1'b0;
    @(negedge clk);
    chk("burst_rvalid_last", ren_rvalid, 1);
    chk("burst_rdata_last", ren_rdata, 32'h104);
    step();
    step();

    // Starvation guard with render held continuously
    ren_req  = 1'b1;
    ren_addr = 12'h300;
    w4_acc   = 1'b0;
    for (int t = 0; t < 96; t++) begin
      if (t < 4)
        drive_wr(1'b1, 12'h040 + 12'(t), 32'hA0000000 + 32'(t));
      else if (!w4_acc)
        drive_wr(1'b1, 12'h044, 32'hA0000004);
      else
        drive_wr(1'b0, '0, '0);
      @(negedge clk);
      exp_force = (t >= 17) && ((t - 17) % 17 == 0) && (t <= 85);
      chk("starve_grant", ren_grant, !exp_force);
      chk("starve_we", mem_we, exp_force);
      if (t < 4) chk("starve_nowait", cpu_waitrequest, 0);
      if (t == 4) chk("full_wait", cpu_waitrequest, 1);
      if (t >= 4 && !w4_acc && !cpu_waitrequest) w4_acc = 1'b1;
      step();
    end
    ren_req = 1'b0;
    step();
    chk("starve_w4_accepted", w4_acc, 1);
    chk("starve_drained", wq.size(), 0);

    // Push on the same cycle as a pop with three entries queued
    ren_req  = 1'b1;
    ren_addr = 12'h380;
    for (int t = 0; t < 3; t++) begin
      drive_wr(1'b1, 12'h050 + 12'(t), 32'hB0000000 + 32'(t));
      step();
    end
    ren_req = 1'b0;
    drive_wr(1'b1, 12'h053, 32'hB0000003);
    @(negedge clk);
    chk("pp_nowait", cpu_waitrequest, 0);
    chk("pp_pop", mem_we, 1);
    step();
    drive_wr(1'b0, '0, '0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("pp_drain_we", mem_we, t < 3);
      step();
    end
    chk("pp_drained", wq.size(), 0);

    // Reset right after a grant with two writes queued
    ren_req  = 1'b1;
    ren_addr = 12'h3C0;
    for (int t = 0; t < 2; t++) begin
      drive_wr(1'b1, 12'h060 + 12'(t), 32'hC0000000 + 32'(t));
      step();
    end
    drive_wr(1'b0, '0, '0);
    @(negedge clk);
    chk("rst_pre_grant", ren_grant, 1);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rvalid", ren_rvalid, 0);
    chk("rst_we", mem_we, 0);
    step();
    reset   = 1'b0;
    ren_req = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("post_rst_rvalid", ren_rvalid, 0);
      chk("post_rst_we", mem_we, 0);
      chk("post_rst_grant", ren_grant, 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_vram_arbiter.md
Name: ppu_vram_arbiter

Overview:
- Shares one single-port synchronous PPU memory (tile buffer, tile graphics, sprite graphics, palettes, OAM) between two requesters: CPU bus writes and the PPU render fetch pipeline (reads).
- Render reads have priority. CPU writes are buffered in a small FIFO and drained in idle slots.
- A starvation guard forces a CPU slot after a bounded wait.
- Sits between the bus slave decode in ppu_top and the memory instances.

Parameters:
- ADDR_W, 12, memory word address width
- DATA_W, 32, memory data width
- FIFO_DEPTH, 4, CPU write FIFO entries; power of two, ≥2
- STARVE_LIMIT, 16, consecutive unserved cycles with FIFO non-empty before a CPU slot is forced

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_chipselect  in  1  bus select
- cpu_write  in  1  bus write strobe
- cpu_address  in  ADDR_W  write address
- cpu_write_data  in  DATA_W  write data
- cpu_waitrequest  out  1  stall; bus holds request while high
- ren_req  in  1  render read request, level
- ren_addr  in  ADDR_W  render read address
- ren_grant  out  1  render read issued this cycle
- ren_rvalid  out  1  render read data valid
- ren_rdata  out  DATA_W  render read data
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, 1-cycle latency after address

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. All state clears on the first edge with reset high:
  - FIFO empty, pointers 0
  - starve_cnt = 0
  - slot register = IDLE
  - ren_rvalid = 0
- Reset mid-operation: any in-flight read is dropped (no rvalid after reset) and queued writes are discarded.
- Push:
  - push = cpu_chipselect & cpu_write & !full.
  - cpu_waitrequest = cpu_chipselect & cpu_write & full (combinational).
  - No push when full, even if a pop occurs the same cycle.
- Slot selection each cycle (combinational, registered into slot):
  - force_cpu = !empty & (starve_cnt == STARVE_LIMIT).
  - If ren_req & !force_cpu: READ. mem_addr = ren_addr, mem_we = 0, ren_grant = 1.
  - Else if !empty: WRITE. mem_addr/mem_wdata = FIFO head, mem_we = 1, pop.
  - Else: IDLE. mem_we = 0, mem_addr = 0, mem_wdata = 0.
- ren_grant is 0 whenever the slot is not READ. The render side must hold ren_req/ren_addr until granted.
- Read return: ren_rvalid = registered (slot == READ), i.e. exactly 1 cycle after ren_grant.
  - ren_rdata = mem_rdata when ren_rvalid, else 0.
  - Back-to-back grants give back-to-back rvalid.
- Starvation counter:
  - Cleared on pop or when empty.
  - Otherwise +1 per cycle, saturating at STARVE_LIMIT.
  - A forced slot pops, which clears the counter. Worst-case render gap is 1 cycle per STARVE_LIMIT+1 cycles.
- Simultaneous push and pop: allowed when not full. Count unchanged; FIFO order preserved.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Ordering: a render read to an address with a pending queued write returns the old data. This is accepted: the CPU updates only during vblank by software contract.
- Writes to memory occur in CPU issue order. No write is lost or duplicated.

Decomposition:
- ppu_pkg holds:
  - typedef slot_t enum {SLOT_IDLE, SLOT_READ, SLOT_WRITE}
  - typedef wr_entry_t struct {addr, data}
  - constants PPU_ADDR_W=12, PPU_DATA_W=32
- Sub-module ppu_wr_fifo: synchronous FIFO, DEPTH parameter, push/pop/full/empty/head. The arbiter instantiates it and contains the slot logic, starvation counter and rvalid pipeline.

Test Plan:
- Reset then idle: all outputs 0, cpu_waitrequest 0, mem_we 0 for 10 cycles.
- CPU writes 0x010←0xDEADBEEF with ren_req=0 → mem_we=1, mem_addr=0x010, mem_wdata=0xDEADBEEF on the next cycle; FIFO empty afterwards.
- ren_req held with addresses 0x100..0x103, memory model returns addr+1 → ren_grant for 4 consecutive cycles; ren_rvalid one cycle later each, ren_rdata 0x101..0x104 in order.
- ren_req held continuously, CPU issues 5 writes → 5th write sees cpu_waitrequest=1. First write is forced after STARVE_LIMIT=16 cycles (ren_grant=0 exactly that cycle), then one forced write every 17 cycles; write order and data match.
- Push on the same cycle as a pop with 3 entries queued → no waitrequest; all 4 writes emerge in order.
- Reset asserted one cycle after ren_grant with 2 writes queued → no ren_rvalid, no further mem_we, FIFO empty after reset.
